video_console_ctrl: RTL and testbench
=====================================

Name: video_console_ctrl

Overview:
Text-console sequencer that turns a byte stream of ASCII characters into byte writes on the video RAM's write port. It tracks a cursor over the 98x36 character grid and handles CR, LF, form-feed and line wrap. On row advance it clears the new row (ring-style scroll), so the on-screen text never needs copying. It sits between a UART/debug character source and the video RAM slave, alongside or in place of CPU writes.

Parameters:
COLS, 98, characters per row
ROWS, 36, rows per screen
BASE_ADDR, 32'h0000_0000, bus byte address of character cell 0
CLR_ON_RST, 1, 1 = clear the whole screen automatically after reset

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
i_ch_valid  input  1  character available
i_ch  input  8  character code
o_ch_ready  output  1  character accepted when i_ch_valid && o_ch_ready
o_wr_req  output  1  write request to video RAM, held until granted
i_wr_gnt  input  1  write grant; a transfer completes on a cycle with o_wr_req && i_wr_gnt
o_wr_addr  output  32  BASE_ADDR + cell index, byte address
o_wr_be  output  4  one-hot byte enable = 1 << idx[1:0]
o_wr_data  output  32  write byte replicated four times
o_cur_col  output  7  cursor column, 0..COLS-1
o_cur_row  output  6  cursor row, 0..ROWS-1
o_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: o_wr_req=0, o_ch_ready=0, cursor (0,0), row_base=0.
- After reset, state is CLR_ALL if CLR_ON_RST=1, otherwise IDLE.
- Cell index idx (12 bit) = row_base + col. row_base is a register holding row*COLS, updated by add/subtract/zero. No multiplier.
- States: IDLE, PUT, CLR_ROW, CLR_ALL, TAB (TAB exists only with the optional feature).
- IDLE:
  - o_ch_ready=1. A character accepted in cycle N is decoded in N; o_wr_req rises in N+1 where a write is needed.
  - Printable (0x20..0x7E or >=0x80): go to PUT.
  - 0x0D: col=0; remain in IDLE.
  - 0x0A: col=0; advance row; go to CLR_ROW.
  - 0x0C: col=0, row=0; go to CLR_ALL.
  - Any other code: consumed, no write, remain in IDLE.
- PUT:
  - Write the character at idx.
  - On grant: col+1. If the new col==COLS, set col=0, advance row and go to CLR_ROW; else return to IDLE.
- Row advance: row==ROWS-1 wraps to row 0 with row_base=0; otherwise row+1 and row_base+COLS.
- CLR_ROW:
  - Write 0x00 to cells row_base .. row_base+COLS-1, one per grant, using an internal counter. Cursor is unchanged.
  - After the last grant, go to IDLE.
- CLR_ALL:
  - Write 0x00 to cells 0 .. COLS*ROWS-1 (3527 by default), one per grant.
  - After the last grant, cursor is (0,0); go to IDLE.
- Write-port handshake:
  - o_wr_addr, o_wr_be and o_wr_data stay stable while o_wr_req=1 and !i_wr_gnt.
  - After a grant, the next request may be asserted in the following cycle, so back-to-back writes are 1 per cycle when i_wr_gnt is held high.
  - o_wr_req never drops without a grant.
- o_ch_ready=0 in every state except IDLE. No input buffering.
- rst asserted mid-operation aborts any sequence immediately (no partial-write completion) and restarts from the reset state.

Optional Feature:
- Macro VCON_TAB_EN.
- Defined: 0x09 in IDLE enters TAB, which writes 0x20 at successive cells until col reaches the next multiple of 8. If that would reach or exceed COLS, the remaining cells are filled, then wrap with row advance and CLR_ROW.
- Not defined: 0x09 is consumed and ignored; the TAB state and its logic are absent.

Test Plan:
- CLR_ON_RST=0, send 'A' (0x41) after reset, gnt held 1 -> one write: addr BASE+0, be 4'b0001, data 32'h41414141; cursor (1,0); ready back the cycle after the grant.
- Cursor at (97,0), send 'Z' -> write addr BASE+97, be 4'b0010, data 32'h5A5A5A5A; then 98 zero writes to idx 98..195; cursor (0,1).
- Cursor row 35, send 0x0A -> cursor (0,0); 98 zero writes idx 0..97; o_busy high throughout.
- Hold gnt=0 for 5 cycles during PUT -> o_wr_req, addr, be and data stable; exactly one write after gnt rises.
- Send 0x0C -> exactly 3528 zero writes, idx 0..3527 in order; cursor (0,0); assert rst at write 1000 -> o_wr_req=0 next cycle.
- VCON_TAB_EN, cursor (3,0), send 0x09 -> space writes at idx 3..7; cursor (8,0). Without the macro -> no write; cursor stays (3,0).

Source files
------------

// File: rtl/video_console_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : video_console_ctrl
//  Purpose  : Text-console sequencer. Turns an ASCII byte stream into byte
//             writes on the video RAM write port, tracking a cursor over a
//             COLS x ROWS grid. Handles CR, LF, form-feed and line wrap, and
//             clears each newly entered row so the screen scrolls ring-style.
//  Options  : `define VCON_TAB_EN adds horizontal-tab expansion (TAB state).
//  Revision : 1.0  initial release
// ============================================================================
module video_console_ctrl #(
    parameter int          COLS       = 98,
    parameter int          ROWS       = 36,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          CLR_ON_RST = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ch_valid,
    input  logic [7:0]  i_ch,
    output logic        o_ch_ready,
    output logic        o_wr_req,
    input  logic        i_wr_gnt,
    output logic [31:0] o_wr_addr,
    output logic [3:0]  o_wr_be,
    output logic [31:0] o_wr_data,
    output logic [6:0]  o_cur_col,
    output logic [5:0]  o_cur_row,
    output logic        o_busy
);

    localparam logic [6:0]  c_COLS7    = 7'(COLS);
    localparam logic [11:0] c_COLS12   = 12'(COLS);
    localparam logic [5:0]  c_ROW_LAST = 6'(ROWS - 1);
    localparam logic [11:0] c_LAST_ROW = 12'(COLS - 1);
    localparam logic [11:0] c_LAST_ALL = 12'(COLS * ROWS - 1);

`ifdef VCON_TAB_EN
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PUT     = 3'd1,
        S_CLR_ROW = 3'd2,
        S_CLR_ALL = 3'd3,
        S_TAB     = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PUT     = 3'd1,
        S_CLR_ROW = 3'd2,
        S_CLR_ALL = 3'd3
    } state_t;
`endif

    state_t      r_state, w_state_nxt;
    logic [6:0]  r_col, w_col_nxt;
    logic [5:0]  r_row, w_row_nxt;
    logic [11:0] r_row_base, w_base_nxt;   // always row * COLS, kept incrementally
    logic [11:0] r_cnt, w_cnt_nxt;         // clear sequence cell counter
    logic [7:0]  r_ch, w_ch_nxt;           // latched printable character
    logic        r_wr_req;
    logic        r_ch_ready;

    logic        w_accept;
    logic        w_fire;
    logic [6:0]  w_col_inc;
    logic [5:0]  w_adv_row;
    logic [11:0] w_adv_base;
    logic        w_printable;
    logic [11:0] w_idx;
    logic [7:0]  w_byte;

    assign w_accept    = i_ch_valid && r_ch_ready;
    assign w_fire      = r_wr_req && i_wr_gnt;
    assign w_col_inc   = r_col + 7'd1;
    assign w_adv_row   = (r_row == c_ROW_LAST) ? 6'd0  : r_row + 6'd1;
    assign w_adv_base  = (r_row == c_ROW_LAST) ? 12'd0 : r_row_base + c_COLS12;
    assign w_printable = (i_ch >= 8'h20) && (i_ch != 8'h7F);

    // Next-state, cursor and counter update logic
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_base_nxt  = r_row_base;
        w_cnt_nxt   = r_cnt;
        w_ch_nxt    = r_ch;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_printable) begin
                        w_ch_nxt    = i_ch;
                        w_state_nxt = S_PUT;
                    end else if (i_ch == 8'h0D) begin
                        w_col_nxt = 7'd0;
                    end else if (i_ch == 8'h0A) begin
                        w_col_nxt   = 7'd0;
                        w_row_nxt   = w_adv_row;
                        w_base_nxt  = w_adv_base;
                        w_cnt_nxt   = 12'd0;
                        w_state_nxt = S_CLR_ROW;
                    end else if (i_ch == 8'h0C) begin
                        w_col_nxt   = 7'd0;
                        w_row_nxt   = 6'd0;
                        w_base_nxt  = 12'd0;
                        w_cnt_nxt   = 12'd0;
                        w_state_nxt = S_CLR_ALL;
`ifdef VCON_TAB_EN
                    end else if (i_ch == 8'h09) begin
                        w_state_nxt = S_TAB;
`endif
                    end
                end
            end
            S_PUT: begin
                if (w_fire) begin
                    if (w_col_inc == c_COLS7) begin
                        w_col_nxt   = 7'd0;
                        w_row_nxt   = w_adv_row;
                        w_base_nxt  = w_adv_base;
                        w_cnt_nxt   = 12'd0;
                        w_state_nxt = S_CLR_ROW;
                    end else begin
                        w_col_nxt   = w_col_inc;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_CLR_ROW: begin
                if (w_fire) begin
                    if (r_cnt == c_LAST_ROW) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 12'd1;
                    end
                end
            end
            S_CLR_ALL: begin
                if (w_fire) begin
                    if (r_cnt == c_LAST_ALL) begin
                        w_col_nxt   = 7'd0;
                        w_row_nxt   = 6'd0;
                        w_base_nxt  = 12'd0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 12'd1;
                    end
                end
            end
`ifdef VCON_TAB_EN
            S_TAB: begin
                // Fill spaces up to the next tab stop; a stop past the row end wraps
                if (w_fire) begin
                    if (w_col_inc == c_COLS7) begin
                        w_col_nxt   = 7'd0;
                        w_row_nxt   = w_adv_row;
                        w_base_nxt  = w_adv_base;
                        w_cnt_nxt   = 12'd0;
                        w_state_nxt = S_CLR_ROW;
                    end else begin
                        w_col_nxt = w_col_inc;
                        if (w_col_inc[2:0] == 3'd0) begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Cell index and write byte selected by the active sequence
    always_comb begin
        w_idx  = r_row_base + {5'd0, r_col};
        w_byte = r_ch;
        case (r_state)
            S_CLR_ROW: begin
                w_idx  = r_row_base + r_cnt;
                w_byte = 8'h00;
            end
            S_CLR_ALL: begin
                w_idx  = r_cnt;
                w_byte = 8'h00;
            end
`ifdef VCON_TAB_EN
            S_TAB: w_byte = 8'h20;
`endif
            default: ;
        endcase
    end

    // State and datapath registers; request/ready follow the next state so both are low out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= (CLR_ON_RST != 0) ? S_CLR_ALL : S_IDLE;
            r_col      <= 7'd0;
            r_row      <= 6'd0;
            r_row_base <= 12'd0;
            r_cnt      <= 12'd0;
            r_ch       <= 8'h00;
            r_wr_req   <= 1'b0;
            r_ch_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_col      <= w_col_nxt;
            r_row      <= w_row_nxt;
            r_row_base <= w_base_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ch       <= w_ch_nxt;
            r_wr_req   <= (w_state_nxt != S_IDLE);
            r_ch_ready <= (w_state_nxt == S_IDLE);
        end
    end

    assign o_ch_ready = r_ch_ready;
    assign o_wr_req   = r_wr_req;
    assign o_wr_addr  = BASE_ADDR + {20'd0, w_idx};
    assign o_wr_be    = 4'b0001 << w_idx[1:0];
    assign o_wr_data  = {4{w_byte}};
    assign o_cur_col  = r_col;
    assign o_cur_row  = r_row;
    assign o_busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_video_console_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_video_console_ctrl
//  Purpose  : Directed self-checking bench for video_console_ctrl
//             (CLR_ON_RST=0, non-zero base address). Tab expectations
//             follow VCON_TAB_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_video_console_ctrl;

    localparam logic [31:0] c_BASE = 32'h0040_0000;

    logic        clk;
    logic        rst;
    logic        i_ch_valid;
    logic [7:0]  i_ch;
    logic        o_ch_ready;
    logic        o_wr_req;
    logic        i_wr_gnt;
    logic [31:0] o_wr_addr;
    logic [3:0]  o_wr_be;
    logic [31:0] o_wr_data;
    logic [6:0]  o_cur_col;
    logic [5:0]  o_cur_row;
    logic        o_busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Completed writes: {addr[67:36], be[35:32], data[31:0]}
    logic [67:0] wq[$];

    video_console_ctrl #(
        .COLS       (98),
        .ROWS       (36),
        .BASE_ADDR  (c_BASE),
        .CLR_ON_RST (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_ch_valid (i_ch_valid),
        .i_ch       (i_ch),
        .o_ch_ready (o_ch_ready),
        .o_wr_req   (o_wr_req),
        .i_wr_gnt   (i_wr_gnt),
        .o_wr_addr  (o_wr_addr),
        .o_wr_be    (o_wr_be),
        .o_wr_data  (o_wr_data),
        .o_cur_col  (o_cur_col),
        .o_cur_row  (o_cur_row),
        .o_busy     (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every completed transfer
    always @(posedge clk) begin
        if (o_wr_req && i_wr_gnt) wq.push_back({o_wr_addr, o_wr_be, o_wr_data});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while ((o_busy || !o_ch_ready) && n < max) begin
            tick();
            n++;
        end
        if (n >= max) chk("idle_timeout", 32'(n), 32'(max - 1));
    endtask

    task automatic send_ch(input logic [7:0] c);
        int n = 0;
        while (!o_ch_ready && n < 5000) begin
            tick();
            n++;
        end
        if (n >= 5000) chk("ready_timeout", 32'(n), 32'd0);
        i_ch_valid = 1'b1;
        i_ch       = c;
        tick();
        i_ch_valid = 1'b0;
        i_ch       = 8'h00;
    endtask

    task automatic put(input logic [7:0] c);
        send_ch(c);
        wait_idle(5000);
    endtask

    // Count logged writes that deviate from zero-fill of consecutive cells starting at first
    function automatic int bad_clear(input int first, input int num);
        int bad = 0;
        for (int i = 0; i < num; i++) begin
            logic [31:0] ea;
            logic [3:0]  eb;
            ea = c_BASE + 32'(first + i);
            eb = 4'(1 << ((first + i) % 4));
            if (wq[i][67:36] !== ea || wq[i][35:32] !== eb || wq[i][31:0] !== 32'h0) bad++;
        end
        return bad;
    endfunction

    initial begin
        logic [31:0] s_addr, s_data;
        logic [3:0]  s_be;
        int          unstable;
        int          busy_cyc;
        int          guard;

        rst        = 1'b1;
        i_ch_valid = 1'b0;
        i_ch       = 8'h00;
        i_wr_gnt   = 1'b1;
        repeat (3) tick();

        // Reset state
        chk("rst_wr_req", 32'(o_wr_req), 32'd0);
        chk("rst_ready",  32'(o_ch_ready), 32'd0);
        chk("rst_busy",   32'(o_busy), 32'd0);
        chk("rst_col",    32'(o_cur_col), 32'd0);
        chk("rst_row",    32'(o_cur_row), 32'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", 32'(o_ch_ready), 32'd1);

        // Single printable character at cell 0
        send_ch(8'h41);
        chk("A_req",  32'(o_wr_req), 32'd1);
        chk("A_addr", o_wr_addr, c_BASE);
        chk("A_be",   32'(o_wr_be), 32'b0001);
        chk("A_data", o_wr_data, 32'h4141_4141);
        chk("A_ready_low", 32'(o_ch_ready), 32'd0);
        tick();
        chk("A_ready_back", 32'(o_ch_ready), 32'd1);
        chk("A_col", 32'(o_cur_col), 32'd1);
        chk("A_row", 32'(o_cur_row), 32'd0);
        chk("A_nwr", 32'(wq.size()), 32'd1);

        // Fill to column 97, then wrap with 'Z'
        for (int i = 0; i < 96; i++) put(8'h61);
        chk("col97", 32'(o_cur_col), 32'd97);
        wq.delete();
        put(8'h5A);
        chk("Z_nwr",  32'(wq.size()), 32'd99);
        chk("Z_addr", wq[0][67:36], c_BASE + 32'd97);
        chk("Z_be",   32'(wq[0][35:32]), 32'b0010);
        chk("Z_data", wq[0][31:0], 32'h5A5A_5A5A);
        wq.pop_front();
        chk("Z_clr_row1", 32'(bad_clear(98, 98)), 32'd0);
        chk("Z_col", 32'(o_cur_col), 32'd0);
        chk("Z_row", 32'(o_cur_row), 32'd1);

        // CR returns to column 0 without writing
        put(8'h78);
        wq.delete();
        put(8'h0D);
        chk("CR_nwr", 32'(wq.size()), 32'd0);
        chk("CR_col", 32'(o_cur_col), 32'd0);
        chk("CR_row", 32'(o_cur_row), 32'd1);

        // Tab from column 3 of row 1 (cells 101..105 when enabled)
        put(8'h31); put(8'h32); put(8'h33);
        wq.delete();
        put(8'h09);
`ifdef VCON_TAB_EN
        chk("TAB_nwr", 32'(wq.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("TAB_addr", wq[i][67:36], c_BASE + 32'(101 + i));
            chk("TAB_data", wq[i][31:0], 32'h2020_2020);
        end
        chk("TAB_col", 32'(o_cur_col), 32'd8);
`else
        chk("TAB_nwr", 32'(wq.size()), 32'd0);
        chk("TAB_col", 32'(o_cur_col), 32'd3);
`endif
        chk("TAB_row", 32'(o_cur_row), 32'd1);

        // DEL and another control code are swallowed; a high code is printable
        wq.delete();
        put(8'h7F);
        put(8'h01);
        chk("ctl_nwr", 32'(wq.size()), 32'd0);
        put(8'hA5);
        chk("hi_nwr",  32'(wq.size()), 32'd1);
        chk("hi_data", wq[0][31:0], 32'hA5A5_A5A5);
        put(8'h0D);

        // Line-feed down to the last row
        guard = 0;
        while (o_cur_row != 6'd35 && guard < 40) begin
            put(8'h0A);
            guard++;
        end
        chk("LF_row35", 32'(o_cur_row), 32'd35);

        // LF on the last row wraps to row 0 and clears cells 0..97
        wq.delete();
        send_ch(8'h0A);
        busy_cyc = 0;
        while (o_busy && busy_cyc < 200) begin
            tick();
            busy_cyc++;
        end
        chk("LFwrap_busy_cyc", 32'(busy_cyc), 32'd98);
        chk("LFwrap_nwr", 32'(wq.size()), 32'd98);
        chk("LFwrap_clr", 32'(bad_clear(0, 98)), 32'd0);
        chk("LFwrap_col", 32'(o_cur_col), 32'd0);
        chk("LFwrap_row", 32'(o_cur_row), 32'd0);

        // Write port held stable while grant is withheld
        wq.delete();
        i_wr_gnt = 1'b0;
        send_ch(8'h51);
        s_addr = o_wr_addr;
        s_be   = o_wr_be;
        s_data = o_wr_data;
        unstable = 0;
        repeat (5) begin
            tick();
            if (!o_wr_req || o_wr_addr !== s_addr || o_wr_be !== s_be || o_wr_data !== s_data)
                unstable++;
        end
        chk("stall_stable", 32'(unstable), 32'd0);
        chk("stall_addr", s_addr, c_BASE);
        chk("stall_data", s_data, 32'h5151_5151);
        chk("stall_nwr0", 32'(wq.size()), 32'd0);
        i_wr_gnt = 1'b1;
        tick();
        chk("stall_nwr1", 32'(wq.size()), 32'd1);
        tick();
        chk("stall_nwr_final", 32'(wq.size()), 32'd1);
        chk("stall_col", 32'(o_cur_col), 32'd1);

        // Form-feed clears the whole screen in order
        wq.delete();
        put(8'h0C);
        chk("FF_nwr", 32'(wq.size()), 32'd3528);
        chk("FF_order", 32'(bad_clear(0, 3528)), 32'd0);
        chk("FF_col", 32'(o_cur_col), 32'd0);
        chk("FF_row", 32'(o_cur_row), 32'd0);

        // Reset in the middle of a form-feed aborts it
        put(8'h42);
        wq.delete();
        send_ch(8'h0C);
        guard = 0;
        while (wq.size() < 1000 && guard < 2000) begin
            tick();
            guard++;
        end
        chk("FFrst_reach1000", 32'(wq.size()), 32'd1000);
        rst      = 1'b1;
        i_wr_gnt = 1'b0;
        tick();
        chk("FFrst_req",  32'(o_wr_req), 32'd0);
        chk("FFrst_busy", 32'(o_busy), 32'd0);
        chk("FFrst_nwr",  32'(wq.size()), 32'd1000);
        rst      = 1'b0;
        i_wr_gnt = 1'b1;
        tick();
        tick();
        chk("FFrst_ready", 32'(o_ch_ready), 32'd1);
        chk("FFrst_col",   32'(o_cur_col), 32'd0);
        chk("FFrst_row",   32'(o_cur_row), 32'd0);
        chk("FFrst_nwr_after", 32'(wq.size()), 32'd1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
